// File: rtl/sp_instr_sequencer.sv
// Scratchpad instruction sequencer: pops one instruction and expands it into per-row
// DRAM load requests or scratchpad read requests (stores and GEMM operand fetch).
module sp_instr_sequencer #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned MAT_S_W = 4,
    parameter int unsigned ROW_S_W = 2,
    parameter int unsigned STRIDE  = 8,
    localparam int unsigned INSTR_W = 2 + MAT_S_W + WORD_W,
    localparam int unsigned REQ_W   = WORD_W + 2 + MAT_S_W + ROW_S_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic               ld_valid,
    output logic [WORD_W-1:0]  ld_addr,
    output logic [MAT_S_W-1:0] ld_mat_s,
    output logic [ROW_S_W-1:0] ld_row_s,
    input  logic               ld_ready,
    output logic               rd_valid,
    output logic [REQ_W-1:0]   rd_req,
    input  logic               rd_ready,
    output logic               busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StGw,
        StGi,
        StGp
    } state_e;

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;
    localparam logic [1:0] OpGemm  = 2'b11;

    localparam logic [ROW_S_W-1:0] LastRow = {ROW_S_W{1'b1}};

    state_e               state_q, state_d;
    logic [ROW_S_W-1:0]   rc_q, rc_d;
    logic [WORD_W-1:0]    addr_q, addr_d;
    logic [MAT_S_W-1:0]   mat_q, mat_d;

    logic [1:0]           opcode;
    logic                 new_weight;
    logic                 ld_v, rd_v;
    logic                 fire;
    logic [WORD_W-1:0]    row_addr;
    logic [WORD_W-1:0]    rd_addr;
    logic [1:0]           rd_mat_t;
    logic [MAT_S_W-1:0]   rd_mat;
    logic [MAT_S_W-1:0]   w_mat, i_mat, p_mat;

    assign opcode     = instr[INSTR_W-1 -: 2];
    assign new_weight = instr[WORD_W+MAT_S_W-1];

    // GEMM operand matrices live in the low bits of the latched address field.
    assign w_mat = addr_q[3*MAT_S_W-1 -: MAT_S_W];
    assign i_mat = addr_q[2*MAT_S_W-1 -: MAT_S_W];
    assign p_mat = addr_q[MAT_S_W-1 -: MAT_S_W];

    assign row_addr = addr_q + WORD_W'(rc_q) * WORD_W'(STRIDE);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            rc_q    <= '0;
            addr_q  <= '0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            addr_q  <= addr_d;
            mat_q   <= mat_d;
        end
    end

    // Request decode depends only on registered state, never on the ready inputs.
    always_comb begin
        ld_v     = 1'b0;
        rd_v     = 1'b0;
        rd_addr  = '0;
        rd_mat_t = 2'b00;
        rd_mat   = '0;
        unique case (state_q)
            StLoad: ld_v = 1'b1;
            StStore: begin
                rd_v    = 1'b1;
                rd_addr = row_addr;
                rd_mat  = mat_q;
            end
            StGw: begin
                rd_v     = 1'b1;
                rd_mat_t = 2'b01;
                rd_mat   = w_mat;
            end
            StGi: begin
                rd_v     = 1'b1;
                rd_mat_t = 2'b10;
                rd_mat   = i_mat;
            end
            StGp: begin
                rd_v     = 1'b1;
                rd_mat_t = 2'b11;
                rd_mat   = p_mat;
            end
            default: ;
        endcase
    end

    assign fire = (ld_v && ld_ready) || (rd_v && rd_ready);

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        addr_d  = addr_q;
        mat_d   = mat_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    addr_d = instr[WORD_W-1:0];
                    mat_d  = instr[WORD_W+MAT_S_W-1 -: MAT_S_W];
                    rc_d   = '0;
                    unique case (opcode)
                        OpNop:   state_d = StIdle;
                        OpLoad:  state_d = StLoad;
                        OpStore: state_d = StStore;
                        OpGemm:  state_d = new_weight ? StGw : StGi;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StLoad, StStore, StGw, StGi, StGp: begin
                if (fire) begin
                    rc_d = rc_q + 1'b1;
                    if (rc_q == LastRow) begin
                        rc_d = '0;
                        unique case (state_q)
                            StGw:    state_d = StGi;
                            StGi:    state_d = StGp;
                            default: state_d = StIdle;
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced quiet while reset is asserted.
    assign instr_ready = nRST && (state_q == StIdle);
    assign busy        = nRST && (state_q != StIdle);
    assign ld_valid    = nRST && ld_v;
    assign rd_valid    = nRST && rd_v;

    assign ld_addr  = row_addr;
    assign ld_mat_s = mat_q;
    assign ld_row_s = rc_q;
    assign rd_req   = {rd_addr, rd_mat_t, rd_mat, rc_q};

endmodule

// File: tb/tb_sp_instr_sequencer.sv
// Scoreboard bench for sp_instr_sequencer: a reference model expands each accepted
// instruction into its expected request list; a monitor pops and compares DUT requests.
module tb_sp_instr_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        instr_valid = 1'b0;
    logic [37:0] instr = '0;
    logic        instr_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_mat_s;
    logic [1:0]  ld_row_s;
    logic        ld_ready = 1'b1;
    logic        rd_valid;
    logic [39:0] rd_req;
    logic        rd_ready = 1'b1;
    logic        busy;

    sp_instr_sequencer dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_mat_s   (ld_mat_s),
        .ld_row_s   (ld_row_s),
        .ld_ready   (ld_ready),
        .rd_valid   (rd_valid),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_ld;
        logic [31:0] addr;
        logic [1:0]  mat_t;
        logic [3:0]  mat;
        logic [1:0]  row;
    } req_t;

    req_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   handshakes = 0;
    bit   stall_en = 1'b0;
    bit   first_pending = 1'b0;
    bit   nop_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_rows(input bit is_ld, input logic [31:0] base, input logic [31:0] step,
                             input logic [1:0] mat_t, input logic [3:0] mat);
        for (int r = 0; r < 4; r++) begin
            req_t e;
            e.is_ld = is_ld;
            e.addr  = base + step * r;
            e.mat_t = mat_t;
            e.mat   = mat;
            e.row   = 2'(r);
            exp_q.push_back(e);
        end
    endtask

    // Reference model: expected request list of one instruction.
    task automatic model(input logic [37:0] ins);
        logic [1:0]  op;
        logic [3:0]  m;
        logic [31:0] a;
        op = ins[37:36];
        m  = ins[35:32];
        a  = ins[31:0];
        case (op)
            2'b01: push_rows(1'b1, a, 32'd8, 2'b00, m);
            2'b10: push_rows(1'b0, a, 32'd8, 2'b00, m);
            2'b11: begin
                if (m[3]) push_rows(1'b0, 32'd0, 32'd0, 2'b01, a[11:8]);
                push_rows(1'b0, 32'd0, 32'd0, 2'b10, a[7:4]);
                push_rows(1'b0, 32'd0, 32'd0, 2'b11, a[3:0]);
            end
            default: ;
        endcase
    endtask

    // Input monitor: model accepted instructions and check first-request latency.
    always @(negedge CLK) begin
        if (!nRST) begin
            first_pending = 1'b0;
            nop_pending   = 1'b0;
        end else begin
            if (first_pending) check("first_req_latency", 64'(ld_valid | rd_valid), 64'd1);
            if (nop_pending) check("nop_no_request", 64'(ld_valid | rd_valid), 64'd0);
            first_pending = 1'b0;
            nop_pending   = 1'b0;
            if (instr_valid && instr_ready) begin
                model(instr);
                if (instr[37:36] == 2'b00) nop_pending = 1'b1;
                else first_pending = 1'b1;
            end
        end
    end

    // Output monitor: the front of the queue must be presented every valid cycle,
    // which also proves fields hold steady through stalls.
    always @(negedge CLK) begin
        if (nRST) begin
            check("valid_exclusive", 64'(ld_valid && rd_valid), 64'd0);
            check("ready_vs_busy", 64'(instr_ready), 64'(!busy));
            if (ld_valid || rd_valid) begin
                check("busy_with_req", 64'(busy), 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=ld%0b/rd%0b required=none t=%0t",
                             ld_valid, rd_valid, $time);
                end else begin
                    req_t e;
                    e = exp_q[0];
                    check("req_kind_ld", 64'(ld_valid), 64'(e.is_ld));
                    if (e.is_ld) begin
                        check("ld_addr", 64'(ld_addr), 64'(e.addr));
                        check("ld_mat_s", 64'(ld_mat_s), 64'(e.mat));
                        check("ld_row_s", 64'(ld_row_s), 64'(e.row));
                    end else begin
                        check("rd_req", 64'(rd_req), 64'({e.addr, e.mat_t, e.mat, e.row}));
                    end
                    if ((ld_valid && ld_ready) || (rd_valid && rd_ready)) begin
                        void'(exp_q.pop_front());
                        handshakes++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (stall_en) begin
                ld_ready = ($urandom_range(0, 2) != 0);
                rd_ready = ($urandom_range(0, 2) != 0);
            end else begin
                ld_ready = 1'b1;
                rd_ready = 1'b1;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] m, input logic [31:0] a);
        int n;
        instr       = {op, m, a};
        instr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!instr_ready && n < 300);
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted t=%0t", $time);
        end
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 2000);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_instr_ready", 64'(instr_ready), 64'd0);
        check("rst_valids", 64'({ld_valid, rd_valid}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("idle_ready", 64'(instr_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        @(posedge CLK);
        #1;
        send(2'b01, 4'd5, 32'h0000_1000);
        drain("load_drain");
        send(2'b10, 4'd3, 32'hFFFF_FFF8);
        drain("store_wrap_drain");
        send(2'b11, 4'b1000, 32'h0000_0123);
        drain("gemm_nw1_drain");
        send(2'b11, 4'b0000, 32'h0000_0123);
        drain("gemm_nw0_drain");
        send(2'b00, 4'd0, 32'h0);
        send(2'b01, 4'd9, 32'h0000_2000);
        drain("nop_load_drain");

        stall_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            send(op, 4'($urandom_range(0, 15)), a);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge CLK);
            #1;
        end
        drain("random_drain");
        stall_en = 1'b0;

        // Reset in the middle of a GEMM weight phase.
        begin
            int h0;
            int n;
            @(posedge CLK);
            #1;
            h0 = handshakes;
            send(2'b11, 4'b1000, 32'h0000_0456);
            n = 0;
            while (handshakes < h0 + 2 && n < 100) begin
                @(negedge CLK);
                n++;
            end
            check("reset_setup_rows", 64'(handshakes - h0), 64'd2);
            @(posedge CLK);
            #1;
            nRST = 1'b0;
            @(negedge CLK);
            check("midrst_instr_ready", 64'(instr_ready), 64'd0);
            check("midrst_valids", 64'({ld_valid, rd_valid}), 64'd0);
            @(posedge CLK);
            #1;
            exp_q.delete();
            nRST = 1'b1;
            @(negedge CLK);
            check("postrst_valids", 64'({ld_valid, rd_valid}), 64'd0);
            check("postrst_busy", 64'(busy), 64'd0);
            @(posedge CLK);
            #1;
            send(2'b01, 4'd7, 32'h0000_0020);
            drain("postrst_load_drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
